cpu_run_checker: RTL
====================

Name: cpu_run_checker

Overview:
- Self-checking run monitor for the MIPS cores (single-cycle, multi-cycle, pipeline).
- Attaches to a core's regs_debug/pc_debug/instr_debug taps and arms on start. It detects program end using a configurable halt condition, enforces a cycle timeout, then compares NUM_CHECKS expected register values one per cycle.
- Reports pass/fail, fail count and first failing entry. This replaces fixed wait-N-cycles-then-assert checking, so one bench works for every core type.

Parameters:
NUM_CHECKS, 4, number of expectation entries (>=2)
HALT_MODE, 0, 0 = PC equals HALT_PC; 1 = PC unchanged for STABLE_CYCLES; 2 = instr_debug equals HALT_INSTR
HALT_PC, 32'h0000_0058, halt address for mode 0
HALT_INSTR, 32'h0000_000C, halt opcode for mode 2 (syscall)
STABLE_CYCLES, 8, consecutive unchanged-PC cycles for mode 1 (>=2)
SETTLE_CYCLES, 2, cycles waited after halt before checking (>=1)
MAX_CYCLES, 50, RUN-state cycle budget before timeout
CYC_W, 16, cycle counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; arms a run from IDLE or DONE
pc_debug  in  32  core PC
instr_debug  in  32  core current instruction
regs_debug  in  32 x [31:0] unpacked  core register file
exp_idx  in  NUM_CHECKS*5  packed register index per entry; entry k at [5k+4:5k]
exp_val  in  NUM_CHECKS*32  packed expected value per entry; entry k at [32k+31:32k]
exp_en  in  NUM_CHECKS  per-entry enable
busy  out  1  high in RUN/SETTLE/CHECK
done  out  1  high in DONE
pass  out  1  valid when done
timeout  out  1  run ended by MAX_CYCLES
fail_count  out  $clog2(NUM_CHECKS+1)  mismatching enabled entries
first_fail  out  $clog2(NUM_CHECKS)  lowest failing entry index
first_fail_valid  out  1  first_fail meaningful
cycles  out  CYC_W  RUN cycles consumed, saturating

Behaviour:
- FSM states: IDLE, RUN, SETTLE, CHECK, DONE. All outputs are registered.
- Reset, including mid-run: state goes to IDLE; all outputs, counters and the stability tracker are cleared to 0 on the next edge.
- IDLE/DONE + start: enter RUN. Clear cycles, fail_count, first_fail, first_fail_valid, pass, timeout and the stable counter.
- start while busy: ignored.
- RUN:
  - cycles increments each cycle and saturates at all-ones.
  - Halt detect, mode 0: pc_debug==HALT_PC.
  - Halt detect, mode 1: a counter increments when pc_debug equals the previous cycle's PC and resets to 0 otherwise. Halt when the counter reaches STABLE_CYCLES-1.
  - Halt detect, mode 2: instr_debug==HALT_INSTR.
  - Halt -> SETTLE.
  - If cycles==MAX_CYCLES-1 with no halt: set timeout=1 and go to SETTLE.
  - Halt and timeout in the same cycle: halt wins, timeout stays 0.
- SETTLE: hold exactly SETTLE_CYCLES cycles so the final writeback lands, then enter CHECK with entry pointer k=0.
- CHECK: one entry per cycle, k=0..NUM_CHECKS-1. Exactly NUM_CHECKS cycles, then DONE.
  - If exp_en[k] and regs_debug[exp_idx[k]] != exp_val[k]: fail_count increments.
  - On the first such mismatch: first_fail=k, first_fail_valid=1.
  - Disabled entries still consume their cycle, keeping latency deterministic.
  - Index 0 compares regs_debug[0] like any other index.
- DONE: done=1; pass=(fail_count==0)&&!timeout. Results hold until start or reset.
- Expectation inputs are sampled during CHECK only. They must be stable from start until done.

Optional Feature:
- Macro: RUNCHK_STOP_ON_FAIL_EN.
- Defined: CHECK exits to DONE on the cycle after the first mismatch. fail_count saturates at 1; later entries are not examined.
- Undefined: all NUM_CHECKS entries are always examined and fail_count is the total number of mismatches.

Test Plan:
- Multi-cycle core, basic program, HALT_MODE=1, entries {8:0x8, 9:0x7, 10:0xF, 11:0x1}, all enabled -> done within 50+SETTLE+4 cycles; pass=1, fail_count=0, first_fail_valid=0, timeout=0.
- Same program, entry 2 expects 0xE instead of 0xF (macro undefined) -> pass=0, fail_count=1, first_fail=2, first_fail_valid=1.
- Entries 1 and 3 wrong, exp_en=4'b1111: macro undefined -> fail_count=2, first_fail=1; macro defined -> fail_count=1, first_fail=1, done asserted 2 cycles earlier than without the macro.
- HALT_MODE=0 with an unreachable HALT_PC=32'hFFFF_FFF0, MAX_CYCLES=20 -> timeout=1 and cycles=20 at done; pass=0 even if all registers match.
- Reset asserted for 1 cycle during RUN at cycle 10 -> next cycle busy=0, done=0, cycles=0. A new start completes normally with pass=1.
- exp_en=4'b0000 -> CHECK lasts exactly 4 cycles, fail_count=0, pass=1; a start pulse while busy has no effect on cycles.

Source files
------------

// File: rtl/cpu_run_checker.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_checker
// Purpose  : Run monitor for the MIPS cores (single-cycle, multi-cycle,
//            pipeline). Arms on start and watches the core debug taps until
//            the program halts or the cycle budget runs out. It waits a few
//            settle cycles for the last writeback, then compares NUM_CHECKS
//            expected register values, one entry per cycle.
//
// Ports    : clk, reset        clock, synchronous active-high reset
//            start             pulse; arms a run from IDLE or DONE
//            pc_debug          core PC tap
//            instr_debug       core current-instruction tap
//            regs_debug[32]    core register file tap
//            exp_idx/val/en    packed expectation table (entry k at 5k / 32k / k)
//            busy              high in RUN / SETTLE / CHECK
//            done              high in DONE
//            pass              no enabled mismatch and no timeout (valid when done)
//            timeout           run ended by the MAX_CYCLES budget
//            fail_count        number of mismatching enabled entries
//            first_fail(_valid) lowest failing entry index
//            cycles            RUN cycles consumed, saturating
//
// Halt modes: 0 = pc_debug == HALT_PC
//             1 = pc_debug unchanged for STABLE_CYCLES
//             2 = instr_debug == HALT_INSTR
//
// Optional : define RUNCHK_STOP_ON_FAIL_EN to end CHECK right after the first
//            mismatch (fail_count then never exceeds 1).
//
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_checker #(
  parameter int          NUM_CHECKS    = 4,
  parameter int          HALT_MODE     = 0,
  parameter logic [31:0] HALT_PC       = 32'h0000_0058,
  parameter logic [31:0] HALT_INSTR    = 32'h0000_000C,
  parameter int          STABLE_CYCLES = 8,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          MAX_CYCLES    = 50,
  parameter int          CYC_W         = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [31:0]                       pc_debug,
  input  logic [31:0]                       instr_debug,
  input  logic [31:0]                       regs_debug [32],
  input  logic [NUM_CHECKS*5-1:0]           exp_idx,
  input  logic [NUM_CHECKS*32-1:0]          exp_val,
  input  logic [NUM_CHECKS-1:0]             exp_en,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_count,
  output logic [$clog2(NUM_CHECKS)-1:0]     first_fail,
  output logic                              first_fail_valid,
  output logic [CYC_W-1:0]                  cycles
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_FC_W = $clog2(NUM_CHECKS+1);
  localparam int c_FF_W = $clog2(NUM_CHECKS);
  // One counter serves both as the settle timer and the CHECK entry pointer,
  // so it must be wide enough for whichever range is larger.
  localparam int c_K_W  = (($clog2(NUM_CHECKS) > $clog2(SETTLE_CYCLES)) ?
                           $clog2(NUM_CHECKS) : $clog2(SETTLE_CYCLES)) + 1;
  localparam int c_ST_W = $clog2(STABLE_CYCLES) + 1;

  localparam logic [CYC_W-1:0]  c_MAX_LAST    = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0]  c_CYC_ONE     = CYC_W'(1);
  localparam logic [c_K_W-1:0]  c_SETTLE_LAST = c_K_W'(SETTLE_CYCLES - 1);
  localparam logic [c_K_W-1:0]  c_NUM_LAST    = c_K_W'(NUM_CHECKS - 1);
  localparam logic [c_K_W-1:0]  c_K_ONE       = c_K_W'(1);
  localparam logic [c_ST_W-1:0] c_ST_LAST     = c_ST_W'(STABLE_CYCLES - 1);
  localparam logic [c_ST_W-1:0] c_ST_ONE      = c_ST_W'(1);
  localparam logic [c_FC_W-1:0] c_FC_ONE      = c_FC_W'(1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [31:0]       r_prev_pc;
  logic [c_ST_W-1:0] r_stable;
  logic [c_K_W-1:0]  r_k;
  logic [CYC_W-1:0]  r_cycles;
  logic [c_FC_W-1:0] r_fail_count;
  logic [c_FF_W-1:0] r_first_fail;
  logic              r_first_fail_valid;
  logic              r_pass;
  logic              r_timeout;
  logic              r_busy;
  logic              r_done;

  // --------------------------------------------------------------------------
  // Halt detection. All three detectors are always built; HALT_MODE is a
  // constant, so the unused ones are trimmed away by synthesis.
  // --------------------------------------------------------------------------
  logic w_halt_pc;
  logic w_halt_stable;
  logic w_halt_instr;
  logic w_halt;
  logic w_run_timeout;

  assign w_halt_pc     = (pc_debug == HALT_PC);
  // The counter holds the number of consecutive unchanged-PC comparisons seen
  // so far, so reaching STABLE_CYCLES-1 means STABLE_CYCLES identical PCs.
  assign w_halt_stable = (r_stable == c_ST_LAST);
  assign w_halt_instr  = (instr_debug == HALT_INSTR);

  always_comb begin
    w_halt = 1'b0;
    case (HALT_MODE)
      0:       w_halt = w_halt_pc;
      1:       w_halt = w_halt_stable;
      default: w_halt = w_halt_instr;
    endcase
  end

  // A halt on the final budget cycle is a clean halt, not a timeout.
  assign w_run_timeout = (r_cycles == c_MAX_LAST) && !w_halt;

  // --------------------------------------------------------------------------
  // Expectation entry selected by the CHECK pointer
  // --------------------------------------------------------------------------
  logic [4:0]  w_sel_idx;
  logic [31:0] w_sel_val;
  logic        w_sel_en;

  always_comb begin
    w_sel_idx = '0;
    w_sel_val = '0;
    w_sel_en  = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (r_k == c_K_W'(i)) begin
        w_sel_idx = exp_idx[5*i +: 5];
        w_sel_val = exp_val[32*i +: 32];
        w_sel_en  = exp_en[i];
      end
    end
  end

  logic              w_mismatch;
  logic              w_last_entry;
  logic              w_stop;
  logic [c_FC_W-1:0] w_fail_next;

  assign w_mismatch   = (r_state == S_CHECK) && w_sel_en &&
                        (regs_debug[w_sel_idx] != w_sel_val);
  assign w_last_entry = (r_k == c_NUM_LAST);
  assign w_fail_next  = w_mismatch ? (r_fail_count + c_FC_ONE) : r_fail_count;

`ifdef RUNCHK_STOP_ON_FAIL_EN
  // Abort the scan at the first mismatch; later entries are never examined.
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_halt || w_run_timeout) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_k == c_SETTLE_LAST) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_last_entry || w_stop) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_pc          <= '0;
      r_stable           <= '0;
      r_k                <= '0;
      r_cycles           <= '0;
      r_fail_count       <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_pass             <= 1'b0;
      r_timeout          <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
    end else begin
      // Tracks the PC every cycle so the first RUN cycle compares against the
      // PC seen on the arming cycle.
      r_prev_pc <= pc_debug;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_stable           <= '0;
            r_k                <= '0;
            r_cycles           <= '0;
            r_fail_count       <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_timeout          <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cycles != {CYC_W{1'b1}}) begin
            r_cycles <= r_cycles + c_CYC_ONE;
          end
          if (pc_debug == r_prev_pc) begin
            r_stable <= r_stable + c_ST_ONE;
          end else begin
            r_stable <= '0;
          end
          if (w_run_timeout) begin
            r_timeout <= 1'b1;
          end
          r_k <= '0;
        end
        S_SETTLE: begin
          // Wraps to 0 on the last settle cycle so CHECK starts at entry 0.
          if (r_k == c_SETTLE_LAST) begin
            r_k <= '0;
          end else begin
            r_k <= r_k + c_K_ONE;
          end
        end
        S_CHECK: begin
          r_k <= r_k + c_K_ONE;
          if (w_mismatch) begin
            r_fail_count <= w_fail_next;
            if (!r_first_fail_valid) begin
              r_first_fail       <= r_k[c_FF_W-1:0];
              r_first_fail_valid <= 1'b1;
            end
          end
          if (w_state_next == S_DONE) begin
            r_pass <= (w_fail_next == '0) && !r_timeout;
          end
        end
        default: begin
          r_k <= '0;
        end
      endcase

      r_busy <= (w_state_next == S_RUN) || (w_state_next == S_SETTLE) ||
                (w_state_next == S_CHECK);
      r_done <= (w_state_next == S_DONE);
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign timeout          = r_timeout;
  assign fail_count       = r_fail_count;
  assign first_fail       = r_first_fail;
  assign first_fail_valid = r_first_fail_valid;
  assign cycles           = r_cycles;

endmodule

`default_nettype wire
